// File: rtl/xpmwrap_tdpram_bytewr_pipe_pkg.sv
// Shared types and lane-merge helper for the byte-write true-dual-port RAM.
// Contents: write-priority and clear-state enums, and byte_merge(), which
// overlays the enabled byte lanes of a new word onto an old word.
package xpmwrap_pkg;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } wr_prio_e;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_e;

  // Widest word and lane count byte_merge() handles; callers widen into these.
  localparam int unsigned MAX_NB  = 64;
  localparam int unsigned MAX_DW  = 512;
  localparam int unsigned LANE_IW = $clog2(MAX_NB);
  localparam int unsigned DW_IW   = $clog2(MAX_DW);

  // Take bits from new_w where the owning lane's enable is set, else old_w.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] be,
                                                   input int unsigned       bw);
    logic [MAX_DW-1:0] res;
    int unsigned       lane;
    res = old_w;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      lane = (bw == 0) ? MAX_NB : i / bw;
      if (lane < MAX_NB && be[LANE_IW'(lane)]) begin
        res[DW_IW'(i)] = new_w[DW_IW'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xpmwrap_tdpram_bytewr_pipe_if.sv
// Bus bundle for the byte-write TDP RAM: clear control, both access ports,
// read return and collision flags.
// master: drives clr_req and port requests; slave: the RAM itself.
interface xpmwrap_tdpram_bytewr_pipe_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_BYTES  = 4,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned DW = NUM_BYTES * BYTE_WIDTH;

  logic                  clr_req;
  logic                  init_busy;
  logic                  ena;
  logic [NUM_BYTES-1:0]  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DW-1:0]         dina;
  logic [DW-1:0]         douta;
  logic                  douta_vld;
  logic                  enb;
  logic [NUM_BYTES-1:0]  web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DW-1:0]         dinb;
  logic [DW-1:0]         doutb;
  logic                  doutb_vld;
  logic                  coll_ww;
  logic                  coll_rw;

  modport master (
    output clr_req, ena, wea, addra, dina, enb, web, addrb, dinb,
    input  init_busy, douta, douta_vld, doutb, doutb_vld, coll_ww, coll_rw
  );

  modport slave (
    input  clr_req, ena, wea, addra, dina, enb, web, addrb, dinb,
    output init_busy, douta, douta_vld, doutb, doutb_vld, coll_ww, coll_rw
  );
endinterface

// File: rtl/xpmwrap_tdpram_bytewr_pipe_rd_pipe.sv
// Read-return pipeline: carries a valid token and its data word through
// READ_LATENCY register stages. Each stage loads data only when its incoming
// token is set, so the final stage holds the last returned word between strobes.
// Ports: clk, rstn, vld_i/data_i (accepted read, captured word), vld_o/data_o.
module xpmwrap_rd_pipe #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);

  logic          vld_q  [READ_LATENCY];
  logic [DW-1:0] data_q [READ_LATENCY];

  for (genvar s = 0; s < READ_LATENCY; s++) begin : g_stage
    logic          vld_d;
    logic [DW-1:0] data_d;

    if (s == 0) begin : g_head
      assign vld_d  = vld_i;
      assign data_d = data_i;
    end else begin : g_body
      assign vld_d  = vld_q[s-1];
      assign data_d = data_q[s-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q[s]  <= 1'b0;
        data_q[s] <= '0;
      end else begin
        vld_q[s] <= vld_d;
        if (vld_d) begin
          data_q[s] <= data_d;
        end
      end
    end
  end

  assign vld_o  = vld_q[READ_LATENCY-1];
  assign data_o = data_q[READ_LATENCY-1];

endmodule

// File: rtl/xpmwrap_tdpram_bytewr_pipe.sv
// Single-clock true-dual-port RAM with byte-lane writes, a valid-tracked read
// pipeline per port, write/write arbitration, collision flags and a zeroise
// sequencer.
// Ports: clk, rstn (async, active low), bus (slave): clr_req/init_busy,
// port A/B en/we/addr/din/dout/dout_vld, coll_ww, coll_rw.
module xpmwrap_tdpram_bytewr_pipe
  import xpmwrap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned NUM_BYTES    = 4,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned INIT_CLEAR   = 1,
  parameter int unsigned WR_PRIORITY  = 0
) (
  input logic                        clk,
  input logic                        rstn,
  xpmwrap_tdpram_bytewr_pipe_if.slave bus
);

  localparam int unsigned DW    = NUM_BYTES * BYTE_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam wr_prio_e    PRIO  = (WR_PRIORITY != 0) ? PRIO_B : PRIO_A;
  localparam bit          CLR_EN = (INIT_CLEAR != 0);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("xpmwrap_tdpram_bytewr_pipe: READ_LATENCY must be 1..4");
  end
  if (DW > MAX_DW || NUM_BYTES > MAX_NB) begin : g_bad_width
    $error("xpmwrap_tdpram_bytewr_pipe: word wider than byte_merge supports");
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0]        old_w,
                                          input logic [DW-1:0]        new_w,
                                          input logic [NUM_BYTES-1:0] be);
    return DW'(byte_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_NB'(be), BYTE_WIDTH));
  endfunction

  logic [DW-1:0]         mem_q [DEPTH];
  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;
  logic                  coll_ww_q;
  logic                  coll_rw_q;

  logic          acc_a_c, acc_b_c, wr_a_c, wr_b_c, same_addr_c, lane_ovl_c;
  logic [DW-1:0] word_a_c, word_b_c, word_ab_c;

  // Access qualification and per-port write_first words (old word + own lanes).
  assign acc_a_c     = bus.ena & ~busy_q;
  assign acc_b_c     = bus.enb & ~busy_q;
  assign wr_a_c      = acc_a_c & (|bus.wea);
  assign wr_b_c      = acc_b_c & (|bus.web);
  assign same_addr_c = (bus.addra == bus.addrb);
  assign lane_ovl_c  = |(bus.wea & bus.web);
  assign word_a_c    = merge(mem_q[bus.addra], bus.dina, bus.wea);
  assign word_b_c    = merge(mem_q[bus.addrb], bus.dinb, bus.web);

  // Same-address double write: loser's lanes first, then the winner overlays.
  assign word_ab_c = (PRIO == PRIO_A) ? merge(word_b_c, bus.dina, bus.wea)
                                      : merge(word_a_c, bus.dinb, bus.web);

  // Zeroise sequencer: CLEAR walks every word once, READY serves accesses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= CLR_EN ? CLR_CLEAR : CLR_READY;
      clr_cnt_q <= '0;
      busy_q    <= CLR_EN;
    end else begin
      case (state_q)
        CLR_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= CLR_READY;
            busy_q  <= 1'b0;
          end
        end
        CLR_READY: begin
          if (bus.clr_req && CLR_EN) begin
            state_q   <= CLR_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= CLR_READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: contents survive reset; one write per address per cycle.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_a_c && wr_b_c && same_addr_c) begin
      mem_q[bus.addra] <= word_ab_c;
    end else begin
      if (wr_a_c) mem_q[bus.addra] <= word_a_c;
      if (wr_b_c) mem_q[bus.addrb] <= word_b_c;
    end
  end

  // Collision flags, one cycle after the offending access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coll_ww_q <= 1'b0;
      coll_rw_q <= 1'b0;
    end else begin
      coll_ww_q <= wr_a_c & wr_b_c & same_addr_c & lane_ovl_c;
      coll_rw_q <= same_addr_c & ((acc_a_c & ~wr_a_c & wr_b_c) |
                                  (acc_b_c & ~wr_b_c & wr_a_c));
    end
  end

  xpmwrap_rd_pipe #(.READ_LATENCY(READ_LATENCY), .DW(DW)) u_rd_pipe_a (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (acc_a_c),
    .data_i (word_a_c),
    .vld_o  (bus.douta_vld),
    .data_o (bus.douta)
  );

  xpmwrap_rd_pipe #(.READ_LATENCY(READ_LATENCY), .DW(DW)) u_rd_pipe_b (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (acc_b_c),
    .data_i (word_b_c),
    .vld_o  (bus.doutb_vld),
    .data_o (bus.doutb)
  );

  assign bus.init_busy = busy_q;
  assign bus.coll_ww   = coll_ww_q;
  assign bus.coll_rw   = coll_rw_q;

endmodule
